cozy_mem_arbiter: RTL and testbench



---
 rtl/cozy_pkg.sv | 19 +
 rtl/cozy_mem_arbiter.sv | 115 +++++++++++
 tb/tb_cozy_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cozy_pkg.sv
// rtl/cozy_pkg.sv - shared constants and types for the cozy memory subsystem
//
// Purpose: widths of the cozy_memory port, the read-encoding of the byte
// write enables, and the requester ids used by the arbiter's return path.
package cozy_pkg;

  localparam int COZY_ADDR_WIDTH = 13;
  localparam int COZY_DATA_WIDTH = 16;

  // All byte enables low means the access is a read.
  localparam logic [1:0] COZY_BWE_READ = 2'b00;

  // Identifies which port an in-flight read belongs to.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_t;

endpackage

// File: rtl/cozy_mem_arbiter.sv
// rtl/cozy_mem_arbiter.sv - two-port arbiter sharing cozy_memory between CPU and video
//
// Purpose: grants the single memory port to the video fetcher (fixed
// priority) or the CPU, with a starvation guard that lets a waiting CPU
// outrank video once it has been denied STARVE_LIMIT consecutive cycles.
// Read data returns to the port that issued the read one cycle after grant.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/addr/din/bwe          CPU request (bwe == 0 is a read)
//   cpu_gnt                       CPU request accepted this cycle
//   cpu_rvalid/rdata              CPU read return
//   vid_req/addr                  video read request
//   vid_gnt                       video request accepted this cycle
//   vid_rvalid/rdata              video read return
//   mem_addr/din/bwe              drive to cozy_memory
//   mem_dout                      registered read data from cozy_memory
module cozy_mem_arbiter
  import cozy_pkg::*;
#(
  parameter int ADDR_WIDTH   = COZY_ADDR_WIDTH,
  parameter int DATA_WIDTH   = COZY_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_din,
  input  logic [DATA_WIDTH/8-1:0] cpu_bwe,
  output logic                    cpu_gnt,
  output logic                    cpu_rvalid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  input  logic                    vid_req,
  input  logic [ADDR_WIDTH-1:0]   vid_addr,
  output logic                    vid_gnt,
  output logic                    vid_rvalid,
  output logic [DATA_WIDTH-1:0]   vid_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic [DATA_WIDTH/8-1:0] mem_bwe,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             rd_cpu;
  logic             rd_vid;
  logic             rd_gnt;
  req_id_t          gnt_id;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Priority select. Nothing is granted while rst is high so no write can
  // reach the memory during reset.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && starved) begin
        cpu_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  // Memory drive: idle cycles present a harmless read of address 0.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_bwe  = COZY_BWE_READ;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
      mem_bwe  = cpu_bwe;
    end else if (vid_gnt) begin
      mem_addr = vid_addr;
    end
  end

  // Count consecutive denied CPU cycles; a dropped request holds the count.
  always_ff @(posedge clk) begin
    if (rst || cpu_gnt) begin
      starve_cnt <= '0;
    end else if (cpu_req && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Return path: remember which port owns the read issued this cycle.
  assign gnt_id = vid_gnt ? REQ_VID : REQ_CPU;
  assign rd_gnt = vid_gnt || (cpu_gnt && (cpu_bwe == COZY_BWE_READ));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cpu <= 1'b0;
      rd_vid <= 1'b0;
    end else begin
      rd_cpu <= rd_gnt && (gnt_id == REQ_CPU);
      rd_vid <= rd_gnt && (gnt_id == REQ_VID);
    end
  end

  // Gating with rst drops a read that was in flight when reset asserted.
  assign cpu_rvalid = rd_cpu && !rst;
  assign vid_rvalid = rd_vid && !rst;
  assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
  assign vid_rdata  = vid_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_cozy_mem_arbiter.sv
// tb/tb_cozy_mem_arbiter.sv - self-checking bench for cozy_mem_arbiter
module tb_cozy_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_bwe;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [15:0] vid_rdata;
  logic [12:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_bwe;
  logic [15:0] mem_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cozy_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_bwe(cpu_bwe),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_bwe(mem_bwe), .mem_dout(mem_dout)
  );

  // cozy_memory stand-in, DEPTH=4 words (8 bytes), little-endian byte lanes.
  // Odd addresses carry a single byte on lane 0.
  logic [7:0] tb_mem [0:7];
  logic [2:0] ma;
  assign ma = mem_addr[2:0];

  always @(posedge clk) begin
    if (!ma[0]) begin
      if (mem_bwe[0]) tb_mem[ma] <= mem_din[7:0];
      if (mem_bwe[1]) tb_mem[ma + 3'd1] <= mem_din[15:8];
      mem_dout <= {tb_mem[ma + 3'd1], tb_mem[ma]};
    end else begin
      if (mem_bwe[0]) tb_mem[ma] <= mem_din[7:0];
      mem_dout <= {8'h00, tb_mem[ma]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte image of memory, denied-cycle count, and the
  // read (owner + data) expected to come back next cycle.
  logic [7:0]  mdl [0:7];
  int          denied    = 0;
  int          pend_own  = 0;   // 0 none, 1 cpu, 2 video
  logic [15:0] pend_data = '0;

  function automatic logic [15:0] mdl_read(input logic [2:0] a);
    if (a[0]) return {8'h00, mdl[a]};
    return {mdl[a + 3'd1], mdl[a]};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      tb_mem[i] = 8'h00;
      mdl[i]    = 8'h00;
    end
  end

  initial forever begin
    logic        e_cpu, e_vid;
    logic [12:0] e_addr;
    logic [15:0] e_din;
    logic [1:0]  e_bwe;
    logic        e_crv, e_vrv;
    logic [2:0]  a;
    @(negedge clk);
    e_cpu = 1'b0;
    e_vid = 1'b0;
    if (!rst) begin
      if (cpu_req && denied >= STARVE) e_cpu = 1'b1;
      else if (vid_req)                e_vid = 1'b1;
      else if (cpu_req)                e_cpu = 1'b1;
    end
    e_addr = e_cpu ? cpu_addr : (e_vid ? vid_addr : 13'd0);
    e_din  = e_cpu ? cpu_din : 16'd0;
    e_bwe  = e_cpu ? cpu_bwe : 2'b00;
    e_crv  = (pend_own == 1) && !rst;
    e_vrv  = (pend_own == 2) && !rst;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
    chk("vid_gnt", 32'(vid_gnt), 32'(e_vid));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_din", 32'(mem_din), 32'(e_din));
    chk("mem_bwe", 32'(mem_bwe), 32'(e_bwe));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    chk("vid_rvalid", 32'(vid_rvalid), 32'(e_vrv));
    chk("cpu_rdata", 32'(cpu_rdata), e_crv ? 32'(pend_data) : 32'd0);
    chk("vid_rdata", 32'(vid_rdata), e_vrv ? 32'(pend_data) : 32'd0);

    pend_own = 0;
    if (e_vid) begin
      pend_own  = 2;
      pend_data = mdl_read(vid_addr[2:0]);
    end else if (e_cpu && cpu_bwe == 2'b00) begin
      pend_own  = 1;
      pend_data = mdl_read(cpu_addr[2:0]);
    end else if (e_cpu) begin
      a = cpu_addr[2:0];
      if (cpu_bwe[0]) mdl[a] = cpu_din[7:0];
      if (!a[0] && cpu_bwe[1]) mdl[a + 3'd1] = cpu_din[15:8];
    end
    if (rst || e_cpu)  denied = 0;
    else if (cpu_req)  denied = (denied + 1 > STARVE) ? STARVE : denied + 1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic req, input logic [12:0] a, input logic [15:0] d, input logic [1:0] b);
    cpu_req = req; cpu_addr = a; cpu_din = d; cpu_bwe = b;
  endtask

  initial begin
    logic lc, lv;
    rst = 1'b1;
    vid_req = 1'b0; vid_addr = '0;
    // Write presented during reset must not be granted or reach memory.
    cpu_set(1'b1, 13'h0000, 16'hFFFF, 2'b11);
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_mem_bwe", 32'(mem_bwe), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    next_cycle();

    // CPU-only writes.
    cpu_set(1'b1, 13'h0000, 16'h1234, 2'b11);
    @(negedge clk); chk("t1_gnt0", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_set(1'b1, 13'h0002, 16'h5678, 2'b11);
    @(negedge clk); chk("t1_gnt1", 32'(cpu_gnt), 32'd1);
    chk("t1_no_rvalid0", 32'(cpu_rvalid), 32'd0);
    next_cycle();
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t1_no_rvalid1", 32'(cpu_rvalid), 32'd0);
    chk("t1_mem", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h5678_1234);
    next_cycle();

    // CPU read of 0x0002.
    cpu_set(1'b1, 13'h0002, 16'h0, 2'b00);
    @(negedge clk); chk("t2_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t2_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t2_rdata", 32'(cpu_rdata), 32'h5678);
    chk("t2_vid_rvalid", 32'(vid_rvalid), 32'd0);
    next_cycle();

    // Simultaneous requests: video first.
    cpu_set(1'b1, 13'h0000, 16'h0, 2'b00);
    vid_req = 1'b1; vid_addr = 13'h0002;
    @(negedge clk);
    chk("t3_vid_gnt", 32'(vid_gnt), 32'd1);
    chk("t3_cpu_wait", 32'(cpu_gnt), 32'd0);
    next_cycle();
    vid_req = 1'b0;
    @(negedge clk);
    chk("t3_vid_rdata", 32'(vid_rdata), 32'h5678);
    chk("t3_cpu_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t3_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    next_cycle();

    // Starvation guard: exactly STARVE denied cycles, then one CPU grant.
    vid_req = 1'b1; vid_addr = 13'h0000;
    cpu_set(1'b1, 13'h0002, 16'h0, 2'b00);
    for (int i = 0; i < STARVE; i++) begin
      @(negedge clk);
      chk("t4_denied", {31'd0, cpu_gnt}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("t4_vid_low", 32'(vid_gnt), 32'd0);
    next_cycle();
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t4_vid_resume", 32'(vid_gnt), 32'd1);
    chk("t4_cpu_rdata", 32'(cpu_rdata), 32'h5678);
    next_cycle();

    // Reset right after a video read grant.
    @(negedge clk); chk("t5_vid_gnt", 32'(vid_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; vid_req = 1'b0;
    cpu_set(1'b1, 13'h0000, 16'hAAAA, 2'b11);
    @(negedge clk);
    chk("t5_vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("t5_mem_bwe", 32'(mem_bwe), 32'd0);
    next_cycle();
    rst = 1'b0;
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t5_vid_rvalid_after", 32'(vid_rvalid), 32'd0);
    chk("t5_mem_kept", {tb_mem[1], tb_mem[0]}, 32'h1234);
    next_cycle();

    // Byte write to odd address, then reads.
    cpu_set(1'b1, 13'h0001, 16'hBCDE, 2'b01);
    @(negedge clk); chk("t6_wr_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_set(1'b1, 13'h0001, 16'h0, 2'b00);
    next_cycle();
    cpu_set(1'b1, 13'h0000, 16'h0, 2'b00);
    @(negedge clk); chk("t6_odd_rdata", 32'(cpu_rdata), 32'h00DE);
    next_cycle();
    cpu_set(1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk); chk("t6_even_rdata", 32'(cpu_rdata), 32'hDE34);
    next_cycle();

    // Randomized traffic obeying the hold-until-grant contract.
    lc = 1'b0; lv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!cpu_req || lc || ($urandom_range(0, 15) == 0)) begin
        cpu_req  = ($urandom_range(0, 2) != 0);
        cpu_addr = 13'($urandom_range(0, 7));
        cpu_din  = 16'($urandom);
        cpu_bwe  = 2'($urandom_range(0, 3));
      end
      if (!vid_req || lv || ($urandom_range(0, 15) == 0)) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = 13'($urandom_range(0, 7));
      end
      @(negedge clk);
      lc = cpu_gnt;
      lv = vid_gnt;
      next_cycle();
    end

    rst = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    next_cycle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
